core_data_mem: RTL and testbench

CORE_DATA_MEM -- requirements
Module: core_data_mem

---
 rtl/core_data_mem.sv | 105 ++++++++++
 tb/tb_core_data_mem.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_data_mem.sv
// core_data_mem: responder side of the core data req/gnt/rvalid protocol.
// Word-addressed storage with byte-lane writes, a programmable grant delay
// and one registered response cycle per accepted request.
//
// Handshake contract: a transfer is accepted on a rising edge where
// data_req_i=1 and data_gnt_o=1. Only the address/wr/be/wdata values present
// at that edge are used. data_rvalid_o is high for exactly the following
// cycle. data_rdata_o carries read data then and is zero at all other times.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_TRANSFER_WIDTH
`define MEM_TRANSFER_WIDTH 4
`endif

module core_data_mem #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned GNT_WAIT   = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             data_req_i,
    output logic                             data_gnt_o,
    input  logic [`MEM_ADDR_WIDTH-1:0]       data_addr_i,
    input  logic                             data_wr_i,
    input  logic [`MEM_TRANSFER_WIDTH-1:0]   data_be_i,
    input  logic [`DATA_WIDTH-1:0]           data_wdata_i,
    output logic                             data_rvalid_o,
    output logic [`DATA_WIDTH-1:0]           data_rdata_o
);

    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam int unsigned NBYTES     = `MEM_TRANSFER_WIDTH;
    localparam logic [3:0]  GNT_WAIT_C = 4'(GNT_WAIT);

    // Word storage; intentionally not reset.
    logic [`DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [3:0]             wcnt_q, wcnt_d;
    logic                   rvalid_q, rvalid_d;
    logic [`DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                   handshake;
    logic [DEPTH_LOG2-1:0]  word_idx;

    // Byte-offset bits and address bits above the storage range do not
    // select anything: addresses wrap modulo the word count.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_addr_i[`MEM_ADDR_WIDTH-1:DEPTH_LOG2+2],
                                data_addr_i[1:0]};

    assign word_idx = data_addr_i[DEPTH_LOG2+1:2];

    // Grant once the request has waited GNT_WAIT cycles; never during reset.
    assign data_gnt_o = rst_n & data_req_i & (wcnt_q == GNT_WAIT_C);
    assign handshake  = data_req_i & data_gnt_o;

    // Wait counter: counts ungranted request cycles, clears otherwise.
    always_comb begin
        wcnt_d = 4'd0;
        if (data_req_i && !data_gnt_o) begin
            wcnt_d = wcnt_q + 4'd1;
        end
    end

    // Response: one valid cycle per handshake, data only for reads.
    always_comb begin
        rvalid_d = handshake;
        rdata_d  = '0;
        if (handshake && !data_wr_i) begin
            rdata_d = mem_q[word_idx];
        end
    end

    // Control and response registers; a pending response is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q   <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wcnt_q   <= wcnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Byte-lane write into storage at the write handshake edge.
    always_ff @(posedge clk) begin
        if (handshake && data_wr_i) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (data_be_i[i]) begin
                    mem_q[word_idx][i*8 +: 8] <= data_wdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_core_data_mem.sv
// Directed bench for core_data_mem: one instance with zero grant wait, one
// with a three-cycle grant wait. Inputs change on the falling edge and
// outputs are observed shortly after it.

module tb_core_data_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance with GNT_WAIT = 0
  logic        rst0_n, req0, wr0, gnt0, rvalid0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  be0;

  // Instance with GNT_WAIT = 3
  logic        rst3_n, req3, wr3, gnt3, rvalid3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  be3;

  core_data_mem #(.DEPTH_LOG2(10), .GNT_WAIT(0)) dut0 (
    .clk           (clk),
    .rst_n         (rst0_n),
    .data_req_i    (req0),
    .data_gnt_o    (gnt0),
    .data_addr_i   (addr0),
    .data_wr_i     (wr0),
    .data_be_i     (be0),
    .data_wdata_i  (wdata0),
    .data_rvalid_o (rvalid0),
    .data_rdata_o  (rdata0)
  );

  core_data_mem #(.DEPTH_LOG2(10), .GNT_WAIT(3)) dut3 (
    .clk           (clk),
    .rst_n         (rst3_n),
    .data_req_i    (req3),
    .data_gnt_o    (gnt3),
    .data_addr_i   (addr3),
    .data_wr_i     (wr3),
    .data_be_i     (be3),
    .data_wdata_i  (wdata3),
    .data_rvalid_o (rvalid3),
    .data_rdata_o  (rdata3)
  );

  // ---------------- driver tasks ----------------
  task automatic drive0(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    req0 = req; wr0 = wr; addr0 = addr; be0 = be; wdata0 = wd;
  endtask

  task automatic drive3(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    req3 = req; wr3 = wr; addr3 = addr; be3 = be; wdata3 = wd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst0_n = 1'b0;
    rst3_n = 1'b0;
    drive0(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    drive3(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0: got %b expected 0", gnt0); end
    n_cmp++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid0: got %b expected 0", rvalid0); end
    n_cmp++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0: got %h expected 0", rdata0); end
    n_cmp++; if (gnt3 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt3: got %b expected 0", gnt3); end
    n_cmp++; if (rvalid3 !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid3: got %b expected 0", rvalid3); end
    drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    rst0_n = 1'b1;
    rst3_n = 1'b1;
  endtask

  task automatic test_basic;
    @(negedge clk);
    drive0(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    #1;
    n_cmp++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL basic_wr_gnt: got %b expected 1", gnt0); end
    @(negedge clk);
    drive0(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    #1;
    n_cmp++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL basic_rd_gnt: got %b expected 1", gnt0); end
    n_cmp++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL basic_wr_rvalid: got %b expected 1", rvalid0); end
    n_cmp++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL basic_wr_rdata: got %h expected 0", rdata0); end
    @(negedge clk);
    drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL basic_idle_gnt: got %b expected 0", gnt0); end
    n_cmp++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL basic_rd_rvalid: got %b expected 1", rvalid0); end
    n_cmp++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_rdata: got %h expected deadbeef", rdata0); end
    @(negedge clk);
    #1;
    n_cmp++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL basic_idle_rvalid: got %b expected 0", rvalid0); end
    n_cmp++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL basic_idle_rdata: got %h expected 0", rdata0); end
  endtask

  task automatic test_byte_enable;
    logic        t_wr [5];
    logic [31:0] t_addr [5];
    logic [3:0]  t_be [5];
    logic [31:0] t_wd [5];
    logic [31:0] t_exp [5];
    t_wr   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    t_addr = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h20};
    t_be   = '{4'hF, 4'h5, 4'hF, 4'h0, 4'hF};
    t_wd   = '{32'h11223344, 32'hAABBCCDD, 32'h0, 32'hFFFFFFFF, 32'h0};
    t_exp  = '{32'h0, 32'h0, 32'h11BB33DD, 32'h0, 32'h11BB33DD};
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i < 5) drive0(1'b1, t_wr[i], t_addr[i], t_be[i], t_wd[i]);
      else       drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      #1;
      if (i < 5) begin
        n_cmp++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL be_gnt[%0d]: got %b expected 1", i, gnt0); end
      end
      if (i > 0) begin
        n_cmp++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL be_rvalid[%0d]: got %b expected 1", i-1, rvalid0); end
        n_cmp++; if (rdata0 !== t_exp[i-1]) begin n_fail++; $display("FAIL be_rdata[%0d]: got %h expected %h", i-1, rdata0, t_exp[i-1]); end
      end
    end
  endtask

  task automatic test_wrap;
    logic        t_wr [3];
    logic [31:0] t_addr [3];
    logic [31:0] t_exp [3];
    t_wr   = '{1'b1, 1'b0, 1'b0};
    t_addr = '{32'h1000, 32'h0000, 32'h0003};
    t_exp  = '{32'h0, 32'h5, 32'h5};
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i < 3) drive0(1'b1, t_wr[i], t_addr[i], 4'hF, 32'h5);
      else       drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      #1;
      if (i > 0) begin
        n_cmp++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL wrap_rvalid[%0d]: got %b expected 1", i-1, rvalid0); end
        n_cmp++; if (rdata0 !== t_exp[i-1]) begin n_fail++; $display("FAIL wrap_rdata[%0d]: got %h expected %h", i-1, rdata0, t_exp[i-1]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic        t_wr [4];
    logic [31:0] t_addr [4];
    logic [31:0] t_wd [4];
    logic [31:0] t_exp [4];
    int          gnt_cnt;
    t_wr   = '{1'b1, 1'b0, 1'b1, 1'b0};
    t_addr = '{32'h40, 32'h40, 32'h44, 32'h44};
    t_wd   = '{32'hCAFEF00D, 32'h0, 32'h0BADC0DE, 32'h0};
    t_exp  = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0BADC0DE};
    gnt_cnt = 0;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) drive0(1'b1, t_wr[i], t_addr[i], 4'hF, t_wd[i]);
      else       drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      #1;
      if (gnt0 === 1'b1) gnt_cnt++;
      if (i > 0) begin
        n_cmp++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid[%0d]: got %b expected 1", i-1, rvalid0); end
        n_cmp++; if (rdata0 !== t_exp[i-1]) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i-1, rdata0, t_exp[i-1]); end
      end
    end
    n_cmp++; if (gnt_cnt != 4) begin n_fail++; $display("FAIL b2b_gnt_count: got %0d expected 4", gnt_cnt); end
    @(negedge clk);
    #1;
    n_cmp++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_rvalid: got %b expected 0", rvalid0); end
  endtask

  task automatic test_gnt_wait;
    logic exp_g;
    // Write with address/data changing before the grant; only the granted values count.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c < 4) drive3(1'b1, 1'b1, 32'hC, 4'hF, 32'h0BAD0BAD);
      else       drive3(1'b1, 1'b1, 32'h8, 4'hF, 32'h12345678);
      #1;
      exp_g = (c == 4);
      n_cmp++; if (gnt3 !== exp_g) begin n_fail++; $display("FAIL wait_wr_gnt[%0d]: got %b expected %b", c, gnt3, exp_g); end
    end
    @(negedge clk);
    drive3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (rvalid3 !== 1'b1) begin n_fail++; $display("FAIL wait_wr_rvalid: got %b expected 1", rvalid3); end
    n_cmp++; if (rdata3 !== 32'h0) begin n_fail++; $display("FAIL wait_wr_rdata: got %h expected 0", rdata3); end
    // Abandoned request: two cycles of req, then dropped.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c <= 2) drive3(1'b1, 1'b1, 32'h8, 4'hF, 32'hFFFFFFFF);
      else        drive3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      #1;
      n_cmp++; if (gnt3 !== 1'b0) begin n_fail++; $display("FAIL abandon_gnt[%0d]: got %b expected 0", c, gnt3); end
      n_cmp++; if (rvalid3 !== 1'b0) begin n_fail++; $display("FAIL abandon_rvalid[%0d]: got %b expected 0", c, rvalid3); end
    end
    // Read held: grant in the 4th request cycle, rvalid in the 5th.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      drive3(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
      #1;
      exp_g = (c == 4);
      n_cmp++; if (gnt3 !== exp_g) begin n_fail++; $display("FAIL wait_rd_gnt[%0d]: got %b expected %b", c, gnt3, exp_g); end
      n_cmp++; if (rvalid3 !== 1'b0) begin n_fail++; $display("FAIL wait_rd_early_rvalid[%0d]: got %b expected 0", c, rvalid3); end
    end
    @(negedge clk);
    drive3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (rvalid3 !== 1'b1) begin n_fail++; $display("FAIL wait_rd_rvalid: got %b expected 1", rvalid3); end
    n_cmp++; if (rdata3 !== 32'h12345678) begin n_fail++; $display("FAIL wait_rd_rdata: got %h expected 12345678", rdata3); end
  endtask

  task automatic test_reset_pending;
    @(negedge clk);
    drive0(1'b1, 1'b1, 32'h60, 4'hF, 32'h600DF00D);
    #1;
    n_cmp++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL rstp_wr_gnt: got %b expected 1", gnt0); end
    @(negedge clk);
    drive0(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    #1;
    n_cmp++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL rstp_rd_gnt: got %b expected 1", gnt0); end
    @(negedge clk);
    #1;
    n_cmp++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL rstp_pre_rvalid: got %b expected 1", rvalid0); end
    rst0_n = 1'b0;
    #1;
    n_cmp++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL rstp_rvalid: got %b expected 0", rvalid0); end
    n_cmp++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL rstp_rdata: got %h expected 0", rdata0); end
    n_cmp++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL rstp_gnt: got %b expected 0", gnt0); end
    @(negedge clk);
    drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst0_n = 1'b1;
    @(negedge clk);
    drive0(1'b1, 1'b0, 32'h60, 4'h0, 32'h0);
    @(negedge clk);
    drive0(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    #1;
    n_cmp++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL rstp_rd60_rvalid: got %b expected 1", rvalid0); end
    n_cmp++; if (rdata0 !== 32'h600DF00D) begin n_fail++; $display("FAIL rstp_rd60_rdata: got %h expected 600df00d", rdata0); end
    @(negedge clk);
    drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rstp_rd10_rdata: got %h expected deadbeef", rdata0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_byte_enable();
    test_wrap();
    test_back_to_back();
    test_gnt_wait();
    test_reset_pending();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
